// File: rtl/ifq_buffer.sv
// Instruction fetch queue: a small in-order FIFO between fetch and decode that
// predecodes jal/branch/illegal and the jal target as each entry is enqueued.
module ifq_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_inst,
    input  logic [ADDR_WIDTH-1:0]    in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_inst,
    output logic [ADDR_WIDTH-1:0]    out_pc,
    output logic                     out_is_jal,
    output logic                     out_is_branch,
    output logic                     out_illegal,
    output logic [ADDR_WIDTH-1:0]    out_jal_target,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              flush_drops
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [ADDR_WIDTH-1:0] tgt_mem  [DEPTH];
    logic                  jal_mem  [DEPTH];
    logic                  br_mem   [DEPTH];
    logic                  ill_mem  [DEPTH];

    logic [PW-1:0] head, tail;
    logic [PW:0]   cnt;
    logic [15:0]   drops;
    logic          push, pop;

    logic [20:0]           jimm;
    logic [ADDR_WIDTH-1:0] jtarget;
    logic                  pd_jal, pd_br, pd_ill;
    logic [16:0]           drop_sum;

    assign in_ready    = (cnt < FULL);
    assign out_valid   = (cnt != '0);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign count       = cnt;
    assign flush_drops = drops;

    // Predecode once on the way in so decode sees the results with no extra logic.
    assign jimm    = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign jtarget = in_pc + {{(ADDR_WIDTH-21){jimm[20]}}, jimm};
    assign pd_jal  = (in_inst[6:0] == 7'b1101111);
    assign pd_br   = (in_inst[6:0] == 7'b1100011);
    assign pd_ill  = (in_inst[1:0] != 2'b11);

    // A push accepted in the flush cycle is counted as dropped as well.
    assign drop_sum = {1'b0, drops} + 17'(cnt) + 17'(push);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            head  <= '0;
            tail  <= '0;
            drops <= '0;
        end else if (flush) begin
            cnt   <= '0;
            head  <= '0;
            tail  <= '0;
            drops <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail] <= in_inst;
            pc_mem[tail]   <= in_pc;
            tgt_mem[tail]  <= jtarget;
            jal_mem[tail]  <= pd_jal;
            br_mem[tail]   <= pd_br;
            ill_mem[tail]  <= pd_ill;
        end
    end

    always_comb begin
        out_inst       = NOP;
        out_pc         = '0;
        out_jal_target = '0;
        out_is_jal     = 1'b0;
        out_is_branch  = 1'b0;
        out_illegal    = 1'b0;
        if (out_valid) begin
            out_inst       = inst_mem[head];
            out_pc         = pc_mem[head];
            out_jal_target = tgt_mem[head];
            out_is_jal     = jal_mem[head];
            out_is_branch  = br_mem[head];
            out_illegal    = ill_mem[head];
        end
    end
endmodule

// File: tb/tb_ifq_buffer.sv
// Bench for ifq_buffer: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_ifq_buffer;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] in_inst, in_pc;
    logic        in_ready, out_valid, out_is_jal, out_is_branch, out_illegal;
    logic [31:0] out_inst, out_pc, out_jal_target;
    logic [1:0]  count;
    logic [15:0] flush_drops;

    int total = 0;
    int bad   = 0;

    logic [31:0] mq_inst[$];
    logic [31:0] mq_pc[$];
    int          m_drops;

    ifq_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_is_jal(out_is_jal), .out_is_branch(out_is_branch),
        .out_illegal(out_illegal), .out_jal_target(out_jal_target),
        .count(count), .flush_drops(flush_drops)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_target(input logic [31:0] inst, input logic [31:0] pc);
        logic [20:0] j;
        j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        return pc + {{11{j[20]}}, j};
    endfunction

    // Reference model advanced with the inputs that the coming edge will sample.
    task automatic model_step();
        int  sz;
        bit  acc, deq, ov;
        sz  = mq_inst.size();
        acc = in_valid && (sz < DEPTH);
        deq = out_ready && (sz > 0);
        if (rst) begin
            mq_inst.delete(); mq_pc.delete(); m_drops = 0;
        end else if (flush) begin
            m_drops = m_drops + sz + int'(acc);
            if (m_drops > 65535) m_drops = 65535;
            mq_inst.delete(); mq_pc.delete();
        end else begin
            ov = 0;
            if (deq) begin void'(mq_inst.pop_front()); void'(mq_pc.pop_front()); end
            if (acc) begin mq_inst.push_back(in_inst); mq_pc.push_back(in_pc); end
            if (ov) $display("unused");
        end
    endtask

    task automatic check_outputs();
        int sz;
        logic [31:0] hi, hp;
        sz = mq_inst.size();
        chk("in_ready", in_ready, sz < DEPTH);
        chk("out_valid", out_valid, sz > 0);
        chk("count", count, sz);
        chk("flush_drops", flush_drops, m_drops);
        if (sz > 0) begin
            hi = mq_inst[0]; hp = mq_pc[0];
            chk("out_inst", out_inst, hi);
            chk("out_pc", out_pc, hp);
            chk("out_is_jal", out_is_jal, hi[6:0] == 7'h6F);
            chk("out_is_branch", out_is_branch, hi[6:0] == 7'h63);
            chk("out_illegal", out_illegal, hi[1:0] != 2'b11);
            chk("out_jal_target", out_jal_target, ref_target(hi, hp));
        end else begin
            chk("empty_inst", out_inst, 32'h13);
            chk("empty_pc", out_pc, 0);
            chk("empty_target", out_jal_target, 0);
            chk("empty_flags", {out_is_jal, out_is_branch, out_illegal}, 0);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                         input bit rdy, input bit fl);
        in_valid = v; in_inst = inst; in_pc = pc; out_ready = rdy; flush = fl;
    endtask

    initial begin
        int pops;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_inst", out_inst, 32'h13);
        chk("rst_count", count, 0);

        // Single jal push
        drive(1, 32'h0000_006F, 32'h8000_0000, 0, 0); tick();
        chk("jal_valid", out_valid, 1);
        chk("jal_flag", out_is_jal, 1);
        chk("jal_target0", out_jal_target, 32'h8000_0000);
        drive(0, 0, 0, 1, 0); tick();

        // Negative J-immediate
        drive(1, 32'hFFDF_F06F, 32'h8000_0010, 0, 0); tick();
        chk("jal_target_neg", out_jal_target, 32'h8000_000C);
        drive(0, 0, 0, 1, 0); tick();

        // Fill, blocked third push, in-order drain
        drive(1, 32'h0000_0013, 32'h8000_0000, 0, 0); tick();
        drive(1, 32'h0000_0063, 32'h8000_0004, 0, 0); tick();
        chk("full_count", count, 2);
        chk("full_ready", in_ready, 0);
        drive(1, 32'h0000_0013, 32'h8000_0008, 0, 0); tick();
        chk("blocked_count", count, 2);
        chk("first_pc", out_pc, 32'h8000_0000);
        drive(0, 0, 0, 1, 0); tick();
        chk("second_pc", out_pc, 32'h8000_0004);
        chk("second_branch", out_is_branch, 1);
        tick();
        chk("drained", out_valid, 0);

        // Steady stream with pointer wrap
        pops = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) begin
                chk("stream_pc", out_pc, 32'h9000_0000 + 32'(4 * pops));
                pops++;
            end
            drive(1, 32'h0000_0013, 32'h9000_0000 + 32'(4 * k), 1, 0); tick();
            chk("stream_count", count, 1);
        end
        chk("stream_pops", pops, 9);
        drive(0, 0, 0, 1, 0); tick();

        // Flush while full with a blocked push
        drive(1, 32'h13, 32'hA000_0000, 0, 0); tick();
        drive(1, 32'h13, 32'hA000_0004, 0, 0); tick();
        drive(1, 32'h13, 32'hA000_0008, 0, 1); tick();
        chk("flush_full_drops", flush_drops, 2);
        chk("flush_full_count", count, 0);
        chk("flush_full_nop", out_inst, 32'h13);

        // Flush at count=1 with an accepted push
        drive(1, 32'h13, 32'hB000_0000, 0, 0); tick();
        drive(1, 32'h13, 32'hB000_0004, 1, 1); tick();
        chk("flush_one_drops", flush_drops, 4);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] r;
            r = $urandom;
            case ($urandom_range(0, 3))
                0: r[6:0] = 7'h6F;
                1: r[6:0] = 7'h63;
                default: ;
            endcase
            drive($urandom_range(0, 3) != 0, r, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        // Reset mid-operation discards without counting drops
        drive(1, 32'h13, 32'hC000_0000, 0, 0); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_mid_drops", flush_drops, 0);
        chk("rst_mid_count", count, 0);

        // Saturation: each flush cycle with an accepted push drops one entry
        drive(1, 32'h13, 32'hD000_0000, 0, 1);
        for (int k = 0; k < 65534; k++) tick();
        chk("sat_preload", flush_drops, 16'hFFFE);
        drive(1, 32'h13, 32'hD000_0004, 0, 0); tick();
        drive(1, 32'h13, 32'hD000_0008, 0, 1); tick();
        chk("sat_reach", flush_drops, 16'hFFFF);
        drive(1, 32'h13, 32'hD000_000C, 0, 1); tick();
        chk("sat_hold", flush_drops, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
